tbus_mem_responder: RTL and testbench

- Responder (slave) end of the trinity bus (tbus) index/operation channel.
- Accepts one request at a time from the memblock arbiter: read, or masked write.
- Services the request from a local 64-bit-word SRAM model after a fixed latency, then pulses operation_done with the read data.
- Serves as the dcache-side endpoint for load/store units in simulation and integration, and honours the memblock-to-dcache flush.

---
 rtl/tbus_mem_responder_pkg.sv | 9 +
 rtl/tbus_mem_responder_if.sv | 20 ++
 rtl/tbus_mem_responder_mem.sv | 18 +
 rtl/tbus_mem_responder.sv | 76 +++++++
 tb/tb_tbus_mem_responder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tbus_mem_responder_pkg.sv
// trinity_tbus_pkg: shared tbus widths, optype encodings and responder FSM states.
package trinity_tbus_pkg;
  localparam int TBUS_OPTYPE_WIDTH = 2;
  localparam int TBUS_DATA_WIDTH = 64;
  localparam logic [TBUS_OPTYPE_WIDTH-1:0] TBUS_NONE = 2'b00;
  localparam logic [TBUS_OPTYPE_WIDTH-1:0] TBUS_READ = 2'b01;
  localparam logic [TBUS_OPTYPE_WIDTH-1:0] TBUS_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/tbus_mem_responder_if.sv
// tbus_mem_responder_if: tbus index/operation channel between initiator and responder.
interface tbus_mem_responder_if;
  import trinity_tbus_pkg::*;
  logic tbus_index_valid;
  logic tbus_index_ready;
  logic [63:0] tbus_index;
  logic [TBUS_DATA_WIDTH-1:0] tbus_write_data;
  logic [TBUS_DATA_WIDTH-1:0] tbus_write_mask;
  logic [TBUS_OPTYPE_WIDTH-1:0] tbus_operation_type;
  logic [TBUS_DATA_WIDTH-1:0] tbus_read_data;
  logic tbus_operation_done;
  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input tbus_index_ready, tbus_read_data, tbus_operation_done
  );
  modport slave (
    input tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done
  );
endinterface

// File: rtl/tbus_mem_responder_mem.sv
// tbus_resp_mem: 64-bit word array with combinational read and bit-masked synchronous write.
module tbus_resp_mem
  import trinity_tbus_pkg::*;
#(
  parameter int DEPTH_LOG = 10
) (
  input  logic clock,
  input  logic we,
  input  logic [DEPTH_LOG-1:0] addr,
  input  logic [TBUS_DATA_WIDTH-1:0] wdata,
  input  logic [TBUS_DATA_WIDTH-1:0] wmask,
  output logic [TBUS_DATA_WIDTH-1:0] rdata
);
  logic [TBUS_DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG)-1];
  assign rdata = mem[addr];
  always_ff @(posedge clock)
    if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
endmodule

// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: tbus responder servicing one read/masked-write at a time from a local array.
// Define TBUS_RESP_BACKPRESSURE_EN to gate ready with an 8-bit LFSR for random pending cycles.
module tbus_mem_responder
  import trinity_tbus_pkg::*;
#(
  parameter int DEPTH_LOG = 10,
  parameter int LATENCY = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  tbus_mem_responder_if.slave bus
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DEPTH_LOG-1:0] word;
  logic [TBUS_DATA_WIDTH-1:0] data, mask, mem_rdata;
  logic [TBUS_OPTYPE_WIDTH-1:0] op;
  logic ready, accept, done, we;
`ifdef TBUS_RESP_BACKPRESSURE_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock)
    if (reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign ready = state == IDLE && !flush && lfsr[0];
`else
  assign ready = state == IDLE && !flush;
`endif
  assign accept = bus.tbus_index_valid && ready;
  assign done = state == RESP && !flush && !reset;
  assign we = done && op == TBUS_WRITE;
  assign bus.tbus_index_ready = ready;
  assign bus.tbus_operation_done = done;
  assign bus.tbus_read_data = done && (op == TBUS_READ || op == TBUS_WRITE) ? mem_rdata : '0;
  // cnt starts at LATENCY-1 and RESP is entered as it reaches 1, giving LATENCY-1 BUSY cycles
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state != IDLE && flush) state_nx = IDLE;
    else if (state == IDLE && accept) begin
      state_nx = LATENCY == 1 ? RESP : BUSY;
      cnt_nx = CW'(LATENCY - 1);
    end else if (state == BUSY) begin
      state_nx = cnt <= CW'(1) ? RESP : BUSY;
      cnt_nx = cnt - 1'b1;
    end else if (state == RESP) state_nx = IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
      data <= '0;
      mask <= '0;
      op <= TBUS_NONE;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        word <= bus.tbus_index[3 +: DEPTH_LOG];
        data <= bus.tbus_write_data;
        mask <= bus.tbus_write_mask;
        op <= bus.tbus_operation_type;
      end
    end
  tbus_resp_mem #(.DEPTH_LOG(DEPTH_LOG)) u_mem (
    .clock(clock),
    .we(we),
    .addr(word),
    .wdata(data),
    .wmask(mask),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb_tbus_mem_responder: directed checks of handshake, latency, masked writes, flush, reset and aliasing.
module tb_tbus_mem_responder;
  import trinity_tbus_pkg::*;
  logic clk = 0;
  logic reset = 1;
  logic flush = 0;
  int n_chk = 0;
  int n_fail = 0;
  tbus_mem_responder_if b ();
  tbus_mem_responder_if b1 ();
  tbus_mem_responder #(.DEPTH_LOG(10), .LATENCY(2)) dut (.clock(clk), .reset(reset), .flush(flush), .bus(b));
  tbus_mem_responder #(.DEPTH_LOG(10), .LATENCY(1)) dut1 (.clock(clk), .reset(reset), .flush(1'b0), .bus(b1));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd, input logic [63:0] wm);
    b.tbus_index_valid = 1;
    b.tbus_operation_type = op;
    b.tbus_index = idx;
    b.tbus_write_data = wd;
    b.tbus_write_mask = wm;
  endtask

  // Called just after a posedge; returns just after the posedge ending the done cycle.
  task automatic xact(input string tag, input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd,
                      input logic [63:0] wm, output int lat, output logic [63:0] rd);
    int k;
    int rs;
    drive(op, idx, wd, wm);
    k = 0;
    @(negedge clk);
    while (!b.tbus_index_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_accept_timeout"}, 64'(k < 50), 64'd1);
    @(posedge clk);
    #1 b.tbus_index_valid = 0;
    lat = 0;
    rs = 0;
    do begin
      @(negedge clk);
      lat++;
      rs += int'(b.tbus_index_ready);
    end while (!b.tbus_operation_done && lat < 50);
    rd = b.tbus_read_data;
    chk({tag, "_ready_while_busy"}, 64'(rs), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int d;
    logic [63:0] rd;
    logic [8:0] rp, dp;
    logic rd_ok;
    b.tbus_index_valid = 0;
    b.tbus_index = '0;
    b.tbus_write_data = '0;
    b.tbus_write_mask = '0;
    b.tbus_operation_type = TBUS_NONE;
    b1.tbus_index_valid = 0;
    b1.tbus_index = '0;
    b1.tbus_write_data = '0;
    b1.tbus_write_mask = '0;
    b1.tbus_operation_type = TBUS_NONE;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", 64'(b.tbus_index_ready), 64'd1);
    chk("rst_done", 64'(b.tbus_operation_done), 64'd0);
    chk("rst_rdata", b.tbus_read_data, 64'd0);
    @(posedge clk);
    #1;
    xact("wr5", TBUS_WRITE, 64'h28, 64'hDEAD_BEEF_0123_4567, '1, lat, rd);
    chk("wr5_lat", 64'(lat), 64'd2);
    xact("rd5", TBUS_READ, 64'h28, '0, '0, lat, rd);
    chk("rd5_lat", 64'(lat), 64'd2);
    chk("rd5_data", rd, 64'hDEAD_BEEF_0123_4567);
    xact("wr5ff", TBUS_WRITE, 64'h28, '1, '1, lat, rd);
    chk("wr5ff_prewrite", rd, 64'hDEAD_BEEF_0123_4567);
    xact("mwr5", TBUS_WRITE, 64'h28, '0, 64'h0000_0000_FFFF_0000, lat, rd);
    chk("mwr5_prewrite", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    xact("mrd5", TBUS_READ, 64'h28, '0, '0, lat, rd);
    chk("mrd5_data", rd, 64'hFFFF_FFFF_0000_FFFF);
    // Valid held across three reads: accepts every third cycle.
    drive(TBUS_READ, 64'h28, '0, '0);
    rp = '0;
    dp = '0;
    rd_ok = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rp = {rp[7:0], b.tbus_index_ready};
      dp = {dp[7:0], b.tbus_operation_done};
      if (b.tbus_operation_done && b.tbus_read_data !== 64'hFFFF_FFFF_0000_FFFF) rd_ok = 0;
    end
    @(posedge clk);
    #1 b.tbus_index_valid = 0;
    chk("bp_ready_pattern", 64'(rp), 64'(9'b100100100));
    chk("bp_done_pattern", 64'(dp), 64'(9'b001001001));
    chk("bp_rdata", 64'(rd_ok), 64'd1);
    xact("wr7z", TBUS_WRITE, 64'h38, '0, '1, lat, rd);
    // Flush in BUSY.
    drive(TBUS_WRITE, 64'h38, 64'h1111, '1);
    @(negedge clk);
    chk("fb_ready", 64'(b.tbus_index_ready), 64'd1);
    @(posedge clk);
    #1 b.tbus_index_valid = 0;
    flush = 1;
    @(negedge clk);
    chk("fb_done", 64'(b.tbus_operation_done), 64'd0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("fb_idle_ready", 64'(b.tbus_index_ready), 64'd1);
    chk("fb_idle_done", 64'(b.tbus_operation_done), 64'd0);
    @(posedge clk);
    #1;
    xact("fb_rd7", TBUS_READ, 64'h38, '0, '0, lat, rd);
    chk("fb_rd7_data", rd, 64'd0);
    // Flush in RESP.
    drive(TBUS_WRITE, 64'h38, 64'h2222, '1);
    @(negedge clk);
    @(posedge clk);
    #1 b.tbus_index_valid = 0;
    @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    chk("fr_done", 64'(b.tbus_operation_done), 64'd0);
    chk("fr_rdata", b.tbus_read_data, 64'd0);
    @(posedge clk);
    #1 flush = 0;
    xact("fr_rd7", TBUS_READ, 64'h38, '0, '0, lat, rd);
    chk("fr_rd7_data", rd, 64'd0);
    // Flush while valid in IDLE.
    drive(TBUS_READ, 64'h38, '0, '0);
    flush = 1;
    @(negedge clk);
    chk("fi_ready", 64'(b.tbus_index_ready), 64'd0);
    @(posedge clk);
    #1 flush = 0;
    b.tbus_index_valid = 0;
    d = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d += int'(b.tbus_operation_done);
    end
    chk("fi_no_done", 64'(d), 64'd0);
    @(posedge clk);
    #1;
    // Invalid optypes complete with zero data and leave the array alone.
    xact("wr3", TBUS_WRITE, 64'h18, 64'hABCD, '1, lat, rd);
    xact("inv11", 2'b11, 64'h18, '1, '1, lat, rd);
    chk("inv11_lat", 64'(lat), 64'd2);
    chk("inv11_rdata", rd, 64'd0);
    xact("inv00", TBUS_NONE, 64'h18, '1, '1, lat, rd);
    chk("inv00_rdata", rd, 64'd0);
    xact("rd3", TBUS_READ, 64'h18, '0, '0, lat, rd);
    chk("rd3_data", rd, 64'hABCD);
    // Index 0x2000 aliases word 0 with 1024 words; low 3 bits are ignored too.
    xact("alias_wr", TBUS_WRITE, 64'h2000, 64'h5A5A_A5A5_1234_8765, '1, lat, rd);
    xact("alias_rd", TBUS_READ, 64'h0000_0000_0000_0005, '0, '0, lat, rd);
    chk("alias_data", rd, 64'h5A5A_A5A5_1234_8765);
    // Reset mid-operation drops the pending write.
    xact("wr9z", TBUS_WRITE, 64'h48, '0, '1, lat, rd);
    drive(TBUS_WRITE, 64'h48, 64'h77, '1);
    @(negedge clk);
    @(posedge clk);
    #1 b.tbus_index_valid = 0;
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    d = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d += int'(b.tbus_operation_done);
    end
    chk("rst_mid_no_done", 64'(d), 64'd0);
    @(posedge clk);
    #1;
    xact("rd9", TBUS_READ, 64'h48, '0, '0, lat, rd);
    chk("rd9_data", rd, 64'd0);
    // LATENCY=1 instance: done in the cycle right after accept.
    b1.tbus_index_valid = 1;
    b1.tbus_operation_type = TBUS_WRITE;
    b1.tbus_index = 64'h10;
    b1.tbus_write_data = 64'hC0FFEE;
    b1.tbus_write_mask = '1;
    @(negedge clk);
    chk("l1_ready", 64'(b1.tbus_index_ready), 64'd1);
    @(posedge clk);
    #1 b1.tbus_index_valid = 0;
    @(negedge clk);
    chk("l1_wr_done", 64'(b1.tbus_operation_done), 64'd1);
    @(posedge clk);
    #1 b1.tbus_index_valid = 1;
    b1.tbus_operation_type = TBUS_READ;
    @(negedge clk);
    chk("l1_rd_ready", 64'(b1.tbus_index_ready), 64'd1);
    @(posedge clk);
    #1 b1.tbus_index_valid = 0;
    @(negedge clk);
    chk("l1_rd_done", 64'(b1.tbus_operation_done), 64'd1);
    chk("l1_rd_data", b1.tbus_read_data, 64'hC0FFEE);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
